sound_player: RTL

//  - Consumer end of the sound_fsm interface: takes the playSound strobe plus an event select.
//  - Plays a fixed-length square-wave tone on the speaker pin for each event.
//  - Gated by the sound on/off mode; one tone per event type (move, good collision, bad collision).
//  - Sits between sound_fsm and the top-level speaker pad.

---
 rtl/sound_player_if.sv | 19 +
 rtl/sound_player.sv | 92 +++++++++
 2 files changed

// File: rtl/sound_player_if.sv
// Request/response bundle between sound_fsm (master) and sound_player (slave).
interface sound_player_if;
    logic       playSound;
    logic [1:0] sound_sel;
    logic       mode_i;
    logic       speaker_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output playSound, sound_sel, mode_i,
        input  speaker_o, busy_o, done_o
    );

    modport slave (
        input  playSound, sound_sel, mode_i,
        output speaker_o, busy_o, done_o
    );
endinterface

// File: rtl/sound_player.sv
// Plays a fixed-length square-wave tone per sound event, priority bad > good > move.
// Optional SOUND_SWEEP_EN: the bad tone's half-period grows by one on every toggle.
module sound_player #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned HP_MOVE = 2,
    parameter int unsigned HP_GOOD = 3,
    parameter int unsigned HP_BAD  = 5,
    parameter int unsigned DUR     = 20
) (
    input logic           clk,
    input logic           nRst,
    sound_player_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e             state_q;
    logic [1:0]         cur_sel_q;
    logic [CNT_W-1:0]   hp_q, pcnt_q, dcnt_q;
    logic [CNT_W-1:0]   req_hp, hp_next;
    logic               speaker_q, busy_q, done_q;
    logic               req_ok, start;

    assign req_ok = bus.playSound && bus.mode_i && (bus.sound_sel != 2'b11);
    // The select encoding doubles as priority, so a plain compare gives bad > good > move.
    assign start  = req_ok && ((state_q == StIdle) || (bus.sound_sel > cur_sel_q));

    always_comb begin
        case (bus.sound_sel)
            2'b00:   req_hp = CNT_W'(HP_MOVE);
            2'b01:   req_hp = CNT_W'(HP_GOOD);
            default: req_hp = CNT_W'(HP_BAD);
        endcase
    end

    always_comb begin
        hp_next = hp_q;
`ifdef SOUND_SWEEP_EN
        if ((cur_sel_q == 2'b10) && (hp_q != {CNT_W{1'b1}})) begin
            hp_next = hp_q + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= StIdle;
            cur_sel_q <= 2'b00;
            hp_q      <= '0;
            pcnt_q    <= '0;
            dcnt_q    <= '0;
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == StPlay) && !bus.mode_i) begin
                state_q   <= StIdle;
                speaker_q <= 1'b0;
                busy_q    <= 1'b0;
            end else if (start) begin
                state_q   <= StPlay;
                cur_sel_q <= bus.sound_sel;
                hp_q      <= req_hp;
                pcnt_q    <= req_hp - CNT_W'(1);
                dcnt_q    <= CNT_W'(DUR - 1);
                speaker_q <= 1'b0;
                busy_q    <= 1'b1;
            end else if (state_q == StPlay) begin
                if (pcnt_q == '0) begin
                    speaker_q <= ~speaker_q;
                    hp_q      <= hp_next;
                    pcnt_q    <= hp_next - CNT_W'(1);
                end else begin
                    pcnt_q <= pcnt_q - CNT_W'(1);
                end
                // Expiry overrides a toggle on the same edge: the pin always ends low.
                if (dcnt_q == '0) begin
                    state_q   <= StIdle;
                    speaker_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end else begin
                    dcnt_q <= dcnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign bus.speaker_o = speaker_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
endmodule
